// File: rtl/orv64_mul_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// orv64_mul_ctrl_pkg
// Shared types and parameters for the M-extension multiply sequencer:
//   - orv64_mul_type_t   : signedness/width class presented to orv64_mul
//   - orv64_mulc_op_t    : multiply opcode at the EX issue port
//   - orv64_mulc_state_t : sequencer FSM states
//   - mulc_op_to_type()  : opcode -> multiplier type mapping
//   - ORV64_MULC_FUSE_EN : default enable for the one-entry product cache
// ----------------------------------------------------------------------------
package orv64_mul_ctrl_pkg;

    localparam bit ORV64_MULC_FUSE_EN = 1'b1;

    typedef enum logic [2:0] {
        MUL_TYPE_L   = 3'd0,   // signed low half
        MUL_TYPE_HSS = 3'd1,   // high half, signed x signed
        MUL_TYPE_HSU = 3'd2,   // high half, signed x unsigned
        MUL_TYPE_HUU = 3'd3,   // high half, unsigned x unsigned
        MUL_TYPE_W   = 3'd4    // 32-bit word multiply
    } orv64_mul_type_t;

    typedef enum logic [2:0] {
        MULC_MUL    = 3'd0,
        MULC_MULH   = 3'd1,
        MULC_MULHSU = 3'd2,
        MULC_MULHU  = 3'd3,
        MULC_MULW   = 3'd4
    } orv64_mulc_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } orv64_mulc_state_t;

    function automatic orv64_mul_type_t mulc_op_to_type(input orv64_mulc_op_t op);
        case (op)
            MULC_MUL:    mulc_op_to_type = MUL_TYPE_L;
            MULC_MULH:   mulc_op_to_type = MUL_TYPE_HSS;
            MULC_MULHSU: mulc_op_to_type = MUL_TYPE_HSU;
            MULC_MULHU:  mulc_op_to_type = MUL_TYPE_HUU;
            MULC_MULW:   mulc_op_to_type = MUL_TYPE_W;
            default:     mulc_op_to_type = MUL_TYPE_L;
        endcase
    endfunction

endpackage

// File: rtl/orv64_mul_cache.sv
// ----------------------------------------------------------------------------
// orv64_mul_cache
// One-entry product cache. Holds the operands, multiplier type and both
// product halves of the last completed non-word multiply.
//   clk, rst_n      : clock, asynchronous active-low reset (clears valid bit)
//   i_lk_*          : lookup request (opcode and operands), combinational hit
//   o_hit/o_hit_data: hit flag and the stored half matching the opcode
//   i_fill*         : overwrite the entry with a fresh product
// ----------------------------------------------------------------------------
module orv64_mul_cache
    import orv64_mul_ctrl_pkg::*;
#(
    parameter bit FUSE_EN = ORV64_MULC_FUSE_EN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  orv64_mulc_op_t  i_lk_op,
    input  logic [63:0]     i_lk_rs1,
    input  logic [63:0]     i_lk_rs2,
    output logic            o_hit,
    output logic [63:0]     o_hit_data,
    input  logic            i_fill,
    input  orv64_mul_type_t i_fill_type,
    input  logic [63:0]     i_fill_rs1,
    input  logic [63:0]     i_fill_rs2,
    input  logic [63:0]     i_fill_rdh,
    input  logic [63:0]     i_fill_rdl
);

    logic            r_vld;
    logic [63:0]     r_rs1;
    logic [63:0]     r_rs2;
    orv64_mul_type_t r_type;
    logic [63:0]     r_rdh;
    logic [63:0]     r_rdl;

    logic            w_opnd_eq;
    logic            w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
        end else if (i_fill) begin
            r_vld <= 1'b1;
        end
    end

    // Payload is qualified by r_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_rs1  <= i_fill_rs1;
            r_rs2  <= i_fill_rs2;
            r_type <= i_fill_type;
            r_rdh  <= i_fill_rdh;
            r_rdl  <= i_fill_rdl;
        end
    end

    assign w_opnd_eq = r_vld && (i_lk_rs1 == r_rs1) && (i_lk_rs2 == r_rs2);

    // The low product half is independent of signedness, so MUL hits on any
    // stored type; high-half ops need an exact type match.
    always_comb begin
        w_hit      = 1'b0;
        o_hit_data = r_rdh;
        case (i_lk_op)
            MULC_MUL: begin
                w_hit      = w_opnd_eq;
                o_hit_data = r_rdl;
            end
            MULC_MULH, MULC_MULHSU, MULC_MULHU: begin
                w_hit      = w_opnd_eq && (mulc_op_to_type(i_lk_op) == r_type);
                o_hit_data = r_rdh;
            end
            default: w_hit = 1'b0;
        endcase
    end

    assign o_hit = FUSE_EN && w_hit;

endmodule

// File: rtl/orv64_mul_ctrl.sv
// ----------------------------------------------------------------------------
// orv64_mul_ctrl
// Sequencing front-end between the EX-stage M-extension issue port and
// orv64_mul. One request per valid/ready handshake; result held until
// writeback accepts it; EX kill honoured in every state.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid/ready/op/rs1/rs2/tag : issue port
//   kill                        : squash the in-flight request
//   resp_valid/ready/data/tag   : writeback port
//   mul_start/type/rs1/rs2      : multiplier drive (operands registered)
//   mul_complete/rdh/rdl        : multiplier result, one-cycle pulse
// ----------------------------------------------------------------------------
module orv64_mul_ctrl
    import orv64_mul_ctrl_pkg::*;
#(
    parameter bit FUSE_EN = ORV64_MULC_FUSE_EN,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  orv64_mulc_op_t   req_op,
    input  logic [63:0]      req_rs1,
    input  logic [63:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             mul_start,
    output orv64_mul_type_t  mul_type,
    output logic [63:0]      mul_rs1,
    output logic [63:0]      mul_rs2,
    input  logic             mul_complete,
    input  logic [63:0]      mul_rdh,
    input  logic [63:0]      mul_rdl
);

    orv64_mulc_state_t r_state;
    orv64_mulc_state_t w_state_nxt;

    orv64_mulc_op_t    r_op;
    orv64_mul_type_t   r_type;
    logic [63:0]       r_rs1;
    logic [63:0]       r_rs2;
    logic [TAG_W-1:0]  r_tag;
    logic [63:0]       r_resp_data;

    logic              w_accept;
    logic              w_hit;
    logic [63:0]       w_hit_data;
    logic              w_done;
    logic              w_fill;
    logic [63:0]       w_sel_data;

    // rst_n gates ready so that every output reads 0 while reset is held.
    assign req_ready = rst_n && (r_state == ST_IDLE) && !kill;
    assign w_accept  = req_valid && req_ready;
    assign w_done    = (r_state == ST_BUSY) && mul_complete && !kill;
    assign w_fill    = w_done && (r_op != MULC_MULW);

    orv64_mul_cache #(
        .FUSE_EN (FUSE_EN)
    ) u_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_lk_op     (req_op),
        .i_lk_rs1    (req_rs1),
        .i_lk_rs2    (req_rs2),
        .o_hit       (w_hit),
        .o_hit_data  (w_hit_data),
        .i_fill      (w_fill),
        .i_fill_type (r_type),
        .i_fill_rs1  (r_rs1),
        .i_fill_rs2  (r_rs2),
        .i_fill_rdh  (mul_rdh),
        .i_fill_rdl  (mul_rdl)
    );

    always_comb begin
        case (r_op)
            MULC_MUL:  w_sel_data = mul_rdl;
            MULC_MULW: w_sel_data = {{32{mul_rdl[31]}}, mul_rdl[31:0]};
            default:   w_sel_data = mul_rdh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = w_hit ? ST_RESP : ST_BUSY;
            end
            ST_BUSY: begin
                // A kill coinciding with completion has nothing left to drain.
                if (kill)              w_state_nxt = mul_complete ? ST_IDLE : ST_DRAIN;
                else if (mul_complete) w_state_nxt = ST_RESP;
            end
            ST_DRAIN: begin
                if (mul_complete) w_state_nxt = ST_IDLE;
            end
            ST_RESP: begin
                if (kill || resp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= MULC_MUL;
            r_type      <= MUL_TYPE_L;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_tag       <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= req_op;
                r_type <= mulc_op_to_type(req_op);
                r_rs1  <= req_rs1;
                r_rs2  <= req_rs2;
                r_tag  <= req_tag;
                if (w_hit) r_resp_data <= w_hit_data;
            end
            if (w_done) r_resp_data <= w_sel_data;
        end
    end

    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_resp_data;
    assign resp_tag   = r_tag;
    assign mul_start  = (r_state == ST_BUSY) || (r_state == ST_DRAIN);
    assign mul_type   = r_type;
    assign mul_rs1    = r_rs1;
    assign mul_rs2    = r_rs2;

endmodule

// File: doc/orv64_mul_ctrl.md
# orv64_mul_ctrl

Sequencing front-end between the EX-stage M-extension issue port and `orv64_mul`. Accepts one multiply request per valid/ready handshake, drives the multiplier, selects the high or low product half, and holds the result until writeback accepts it. A one-entry product cache lets a MULH[S][U]/MUL pair on identical operands complete with a single multiplier pass. EX-stage kill is supported at every point in the flow.

## Interface
- `FUSE_EN`, default 1: enables the product cache. When 0, every request takes the miss path.
- `TAG_W`, default 5: width of the destination tag.

- `clk`  in  1  clock
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_op`  in  3  `orv64_mulc_op_t`: MUL, MULH, MULHSU, MULHU, MULW
- `req_rs1`, `req_rs2`  in  64 each  operands
- `req_tag`  in  TAG_W  destination tag, returned unchanged
- `kill`  in  1  squash the in-flight request
- `resp_valid`  out  1  result valid
- `resp_ready`  in  1  writeback accepts the result
- `resp_data`  out  64  result
- `resp_tag`  out  TAG_W  tag of the result
- `mul_start`  out  1  multiplier enable, held high through completion
- `mul_type`  out  `orv64_mul_type_t`  signedness/width class
- `mul_rs1`, `mul_rs2`  out  64 each  registered operands
- `mul_complete`  in  1  multiplier done, one-cycle pulse
- `mul_rdh`, `mul_rdl`  in  64 each  product halves, valid while `mul_complete`

## Operation
- FSM states: IDLE, BUSY, DRAIN, RESP.
- **IDLE**
  - `req_ready = !kill`.
  - On accept, register op, operands and tag.
  - Cache hit: load `resp_data`, go to RESP.
  - Miss: go to BUSY.
- **BUSY**
  - `mul_start = 1` and `mul_type` is derived from the registered op:
    - MUL → signed low
    - MULH → signed-signed
    - MULHSU → HSU
    - MULHU → HUU
    - MULW → W
  - On `mul_complete`:
    - Select the result: `mul_rdh` for MULH*; `mul_rdl` for MUL; `{32{mul_rdl[31]}, mul_rdl[31:0]}` for MULW.
    - Fill the cache unless the op is MULW.
    - Go to RESP.
  - `kill` in BUSY: go to DRAIN.
- **DRAIN**
  - `mul_start` stays 1 until `mul_complete`.
  - The product is discarded and the cache is not filled.
  - On `mul_complete`, go to IDLE.
- **RESP**
  - `resp_valid = 1`. `resp_data` and `resp_tag` stay stable while `resp_ready = 0`.
  - If `resp_ready && !kill`: handshake completes, go to IDLE.
  - If `kill`: go to IDLE with no handshake. `kill` wins over a simultaneous `resp_ready`.
- **Cache**
  - One entry: valid bit, rs1, rs2, `mul_type`, rdh, rdl.
  - A MUL request hits on a valid entry with equal rs1 and rs2, for any stored signedness, because the low 64 bits do not depend on signedness. It returns the stored rdl.
  - MULH, MULHSU and MULHU hit only when rs1, rs2 and the stored type all match. They return the stored rdh.
  - MULW never hits and never fills.
  - A fill overwrites the entry. The entry is cleared only by reset.
- A `kill` in IDLE with `req_valid` high blocks acceptance.

## Timing
- All outputs reset to 0; the cache valid bit resets to 0. `req_ready` is 1 in the first cycle after reset deassertion if `kill` is low.
- Reset asserted in any state returns the FSM to IDLE immediately.
- Hit: request accepted in cycle T, `resp_valid` in T+1.
- Miss:
  - Accept in T, `mul_start` high from T+1.
  - `mul_complete` arrives in C, `resp_valid` in C+1.
  - `mul_start` falls in C+1.
- `mul_start` is low for at least one cycle between consecutive multiplier operations, guaranteed by RESP/IDLE.
- `req_ready` is 0 outside IDLE. Peak throughput is one request per 2 cycles on hits.
- `mul_rs1`, `mul_rs2` and `mul_type` are stable throughout BUSY and DRAIN.

## Structure
- Add `orv64_mulc_op_t` (3-bit enum) and the op→`mul_type` mapping function to `orv64_typedef_pkg`. The existing `orv64_mul_type_t` is reused.
- Add `ORV64_MULC_FUSE_EN` to `orv64_param_pkg`.
- One sub-module: `orv64_mul_cache`, holding the entry registers, the hit compare and the fill port.
- `orv64_mul` is instantiated by the parent, not inside this block.

## Test plan
- **Miss path:** MULHU rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 → `mul_start` held until complete; `resp_data`=0x1 one cycle after `mul_complete`; tag echoed.
- **Cache hit:** next request MUL with the same operands → `resp_valid` one cycle after accept, `resp_data`=0xFFFF_FFFF_FFFF_FFFE, `mul_start` stays 0.
- **Type mismatch:** MULH with the same operands → miss; `resp_data`=0xFFFF_FFFF_FFFF_FFFF. A following MULHU with the same operands also misses, because the cache now holds the SS type.
- **MULW:** rs1=0x7FFF_FFFF, rs2=2 → `resp_data`=0xFFFF_FFFF_FFFF_FFFE. A repeat of the same request misses again.
- **Kill in BUSY:** kill 3 cycles after accept → no `resp_valid`; `mul_start` held until `mul_complete`, then IDLE. A subsequent identical MUL misses.
- **Backpressure and reset:**
  - Hold `resp_ready`=0 for 5 cycles → `resp_data`/`resp_tag` stable and `req_ready`=0.
  - `kill` and `resp_ready` high in the same cycle → no handshake, IDLE.
  - `rst_n` asserted mid-BUSY → all outputs 0 and the cache invalid.
